// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } stateT;

    localparam int unsigned LATENCY_MAX = 7;
    localparam int unsigned CNT_W       = 3;

endpackage

// File: rtl/mem_responder_if.sv
// Requester-side strobe/address/data bundle for the memory responder.
interface mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_rd, mem_wr, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_rd, mem_wr, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, registered synchronous read.
// The read register doubles as the responder's rdata and can be cleared.
module mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage write; contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read register: loads on a legal read, zeroes on an illegal read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one word access per strobe assertion,
// waits LATENCY cycles, then performs it and holds ready until release.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst,
    mem_responder_if.slave      bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    stateT             state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       latAddr;
    logic [DATA_W-1:0] latWdata;
    logic              latWr;
    logic              errQ;

    logic              req, both, accept, doAccess;
    logic [31:0]       accAddr;
    logic [DATA_W-1:0] accWdata;
    logic              accWr, accLegal;
    logic              ramWe, ramRe, ramClr;
    logic [ADDR_W-1:0] ramIdx;
    logic [DATA_W-1:0] ramQ;

    assign req  = bus.mem_rd | bus.mem_wr;
    assign both = bus.mem_rd & bus.mem_wr;

    // Next state; the access uses live inputs when it happens on the accept edge.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        doAccess  = 1'b0;
        accAddr   = latAddr;
        accWdata  = latWdata;
        accWr     = latWr;
        case (state)
            IDLE: begin
                accAddr  = bus.addr;
                accWdata = bus.wdata;
                accWr    = bus.mem_wr;
                if (req) begin
                    accept = 1'b1;
                    if (both) begin
                        nextState = DONE;
                    end else if (LATENCY == 0) begin
                        doAccess  = 1'b1;
                        nextState = DONE;
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    doAccess  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                if (!req) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Legality of the address being accessed and the resulting RAM controls.
    always_comb begin
        accLegal = (accAddr[1:0] == 2'b00) && ((accAddr >> (ADDR_W + 2)) == '0);
        ramIdx   = accAddr[ADDR_W+1:2];
        ramWe    = doAccess && accLegal && accWr && !rst;
        ramRe    = doAccess && accLegal && !accWr;
        ramClr   = doAccess && !accLegal && !accWr;
    end

    // State, wait counter, request latch and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            latAddr  <= '0;
            latWdata <= '0;
            latWr    <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                latAddr  <= bus.addr;
                latWdata <= bus.wdata;
                latWr    <= bus.mem_wr;
                cnt      <= CNT_LOAD;
                if (both || !accLegal) begin
                    errQ <= 1'b1;
                end
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) uArray (
        .clk   (clk),
        .rst   (rst),
        .we    (ramWe),
        .re    (ramRe),
        .clr   (ramClr),
        .idx   (ramIdx),
        .wdata (accWdata),
        .rdata (ramQ)
    );

    assign bus.rdata = ramQ;
    assign bus.ready = (state == DONE);
    assign bus.busy  = (state == WAIT);
    assign bus.err   = errQ;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: four responders with LATENCY 0/1/3/7 sharing clk/rst.
module tb_mem_responder;
    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdS    [NDUT];
    logic        wrS    [NDUT];
    logic [31:0] addrS  [NDUT];
    logic [31:0] wdataS [NDUT];
    logic [31:0] rdataO [NDUT];
    logic        readyO [NDUT];
    logic        busyO  [NDUT];
    logic        errO   [NDUT];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    function automatic int latOf(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : (d == 2) ? 3 : 7;
    endfunction

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : gDut
            localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
            mem_responder_if #(.DATA_W(32)) bus ();
            assign bus.mem_rd = rdS[g];
            assign bus.mem_wr = wrS[g];
            assign bus.addr   = addrS[g];
            assign bus.wdata  = wdataS[g];
            assign rdataO[g]  = bus.rdata;
            assign readyO[g]  = bus.ready;
            assign busyO[g]   = bus.busy;
            assign errO[g]    = bus.err;
            mem_responder #(
                .DATA_W  (32),
                .ADDR_W  (10),
                .LATENCY (LAT)
            ) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise strobes, hold them for 'hold' edges, and watch until the DUT is idle.
    // lat is counted in edges after the accept edge.
    task automatic request(input int d, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           output int lat, output int busyCyc, output int readyCyc,
                           output int rises);
        int   n;
        logic prevReady;
        bit   done;
        rdS[d] = rd; wrS[d] = wr; addrS[d] = a; wdataS[d] = wd;
        lat = -1; busyCyc = 0; readyCyc = 0; rises = 0;
        prevReady = 1'b0; done = 1'b0; n = 0;
        while (!done && n < 40) begin
            step();
            n++;
            if (n == 1) begin
                addrS[d]  = ~a;
                wdataS[d] = ~wd;
            end
            if (n == hold) begin
                rdS[d] = 1'b0;
                wrS[d] = 1'b0;
            end
            busyCyc  += int'(busyO[d]);
            readyCyc += int'(readyO[d]);
            if (readyO[d] && !prevReady) begin
                rises++;
                if (lat < 0) lat = n - 1;
            end
            prevReady = readyO[d];
            if (lat >= 0 && n >= hold && !readyO[d]) done = 1'b1;
        end
        rdS[d] = 1'b0; wrS[d] = 1'b0;
        checkVal($sformatf("d%0d completes", d), 32'(done), 32'd1);
    endtask

    initial begin
        int lat, bc, rc, ri, dd;
        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            rdS[i] = 1'b0; wrS[i] = 1'b0; addrS[i] = '0; wdataS[i] = '0;
        end
        step();
        step();
        for (int i = 0; i < NDUT; i++) begin
            checkVal($sformatf("rst ready d%0d", i), 32'(readyO[i]), 32'd0);
            checkVal($sformatf("rst busy d%0d", i),  32'(busyO[i]),  32'd0);
            checkVal($sformatf("rst err d%0d", i),   32'(errO[i]),   32'd0);
            checkVal($sformatf("rst rdata d%0d", i), rdataO[i],      32'd0);
        end
        rst = 1'b0;
        step();

        // Basic write then read, LATENCY=1.
        request(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2, lat, bc, rc, ri);
        checkVal("l1 wr latency", 32'(lat), 32'd1);
        checkVal("l1 wr err", 32'(errO[1]), 32'd0);
        request(1, 1'b1, 1'b0, 32'h10, 32'h0, 2, lat, bc, rc, ri);
        checkVal("l1 rd latency", 32'(lat), 32'd1);
        checkVal("l1 rd data", rdataO[1], 32'hDEADBEEF);
        checkVal("l1 rd err", 32'(errO[1]), 32'd0);

        // Latency sweep with a 10-cycle strobe.
        for (int k = 0; k < 3; k++) begin
            dd = (k == 0) ? 0 : k + 1;
            request(dd, 1'b0, 1'b1, 32'h40, 32'h11110000 | 32'(latOf(dd)), 10, lat, bc, rc, ri);
            checkVal($sformatf("sweep lat L%0d", latOf(dd)), 32'(lat), 32'(latOf(dd)));
            checkVal($sformatf("sweep busy L%0d", latOf(dd)), 32'(bc), 32'(latOf(dd)));
            checkVal($sformatf("sweep rises L%0d", latOf(dd)), 32'(ri), 32'd1);
            checkVal($sformatf("sweep ready cyc L%0d", latOf(dd)), 32'(rc), 32'(10 - latOf(dd)));
            request(dd, 1'b1, 1'b0, 32'h40, 32'h0, 2, lat, bc, rc, ri);
            checkVal($sformatf("sweep rd L%0d", latOf(dd)), rdataO[dd], 32'h11110000 | 32'(latOf(dd)));
        end

        // Strobe dropped right after accept, LATENCY=3.
        request(2, 1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 1, lat, bc, rc, ri);
        checkVal("drop lat", 32'(lat), 32'd3);
        checkVal("drop busy", 32'(bc), 32'd3);
        checkVal("drop done cyc", 32'(rc), 32'd1);
        request(2, 1'b1, 1'b0, 32'h24, 32'h0, 2, lat, bc, rc, ri);
        checkVal("drop rd", rdataO[2], 32'hCAFEF00D);

        // Illegal addresses, LATENCY=1.
        request(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 2, lat, bc, rc, ri);
        checkVal("wr0 err", 32'(errO[1]), 32'd0);
        request(1, 1'b1, 1'b0, 32'h13, 32'h0, 2, lat, bc, rc, ri);
        checkVal("misalign err", 32'(errO[1]), 32'd1);
        checkVal("misalign rdata", rdataO[1], 32'd0);
        checkVal("misalign lat", 32'(lat), 32'd1);
        request(1, 1'b0, 1'b1, 32'h1000, 32'h00000BAD, 2, lat, bc, rc, ri);
        checkVal("range lat", 32'(lat), 32'd1);
        checkVal("range err", 32'(errO[1]), 32'd1);
        request(1, 1'b1, 1'b0, 32'h0, 32'h0, 2, lat, bc, rc, ri);
        checkVal("ram0 kept", rdataO[1], 32'h12345678);
        checkVal("err sticky", 32'(errO[1]), 32'd1);

        // Both strobes together, LATENCY=3.
        request(2, 1'b1, 1'b1, 32'h24, 32'h0BADBEEF, 2, lat, bc, rc, ri);
        checkVal("both lat", 32'(lat), 32'd0);
        checkVal("both rdata", rdataO[2], 32'hCAFEF00D);
        checkVal("both err", 32'(errO[2]), 32'd1);
        request(2, 1'b1, 1'b0, 32'h24, 32'h0, 2, lat, bc, rc, ri);
        checkVal("both ram kept", rdataO[2], 32'hCAFEF00D);

        // Reset during WAIT of a write to 0x20, LATENCY=3.
        request(2, 1'b0, 1'b1, 32'h20, 32'h55AA55AA, 2, lat, bc, rc, ri);
        wrS[2] = 1'b1; addrS[2] = 32'h20; wdataS[2] = 32'hFFFF0000;
        step();
        checkVal("rstw busy", 32'(busyO[2]), 32'd1);
        step();
        rst = 1'b1; wrS[2] = 1'b0;
        step();
        checkVal("rstw ready", 32'(readyO[2]), 32'd0);
        checkVal("rstw busy0", 32'(busyO[2]), 32'd0);
        checkVal("rstw err", 32'(errO[2]), 32'd0);
        checkVal("rstw rdata", rdataO[2], 32'd0);
        rst = 1'b0;
        step(); step(); step();
        checkVal("rstw idle busy", 32'(busyO[2]), 32'd0);
        checkVal("rstw idle ready", 32'(readyO[2]), 32'd0);
        request(2, 1'b1, 1'b0, 32'h20, 32'h0, 2, lat, bc, rc, ri);
        checkVal("rstw ram8 kept", rdataO[2], 32'h55AA55AA);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
